seven_seg_shifter: RTL and testbench

SEVEN_SEG_SHIFTER -- requirements
Module: seven_seg_shifter

---
 rtl/seven_seg_shifter_pkg.sv | 14 +
 rtl/seven_seg_shifter.sv | 118 +++++++++++
 tb/tb_seven_seg_shifter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_shifter_pkg.sv
// Shared constants and FSM encoding for the 74HC595 seven-segment serialiser.
package seven_seg_shifter_pkg;

    localparam int unsigned WORD_WIDTH  = 16;
    localparam int unsigned CLK_DIV_MAX = 255;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        LATCH
    } state_t;

endpackage

// File: rtl/seven_seg_shifter.sv
// Serialises {ANODE, CATHODE} MSB-first into a 16-bit 74HC595 chain whenever the
// word changes, then pulses RCLK and enables the chain outputs.
module seven_seg_shifter
    import seven_seg_shifter_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] CATHODE,
    input  logic [7:0] ANODE,
    output logic       SER,
    output logic       SCLK,
    output logic       RCLK,
    output logic       OE_N,
    output logic       BUSY
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    if (CLK_DIV < 1 || CLK_DIV > CLK_DIV_MAX) begin : g_bad_div
        $error("seven_seg_shifter: CLK_DIV out of range 1..255");
    end

    state_t                  state;
    logic [WORD_WIDTH-1:0]   word;
    logic [WORD_WIDTH-1:0]   last;
    logic [WORD_WIDTH-2:0]   shreg;
    logic [3:0]              bit_cnt;
    logic [DIV_W-1:0]        div_cnt;
    logic                    sent;
    logic                    ser;
    logic                    sclk;
    logic                    rclk;
    logic                    oe_n;
    logic                    busy;

    assign word = {ANODE, CATHODE};

    // The load clears div_cnt to 0 while every later phase restarts it at 1, so the
    // first SETUP phase absorbs the load cycle and each phase lasts CLK_DIV cycles.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            ser     <= 1'b0;
            sclk    <= 1'b0;
            rclk    <= 1'b0;
            oe_n    <= 1'b1;
            busy    <= 1'b0;
            sent    <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            shreg   <= '0;
            last    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!sent || word != last) begin
                        shreg   <= word[WORD_WIDTH-2:0];
                        last    <= word;
                        sent    <= 1'b1;
                        busy    <= 1'b1;
                        ser     <= word[WORD_WIDTH-1];
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        sclk    <= 1'b1;
                        div_cnt <= DIV_ONE;
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        sclk    <= 1'b0;
                        div_cnt <= DIV_ONE;
                        if (bit_cnt == 4'd15) begin
                            rclk  <= 1'b1;
                            state <= LATCH;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            ser     <= shreg[WORD_WIDTH-2];
                            shreg   <= {shreg[WORD_WIDTH-3:0], 1'b0};
                            state   <= SETUP;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        rclk  <= 1'b0;
                        oe_n  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SER  = ser;
    assign SCLK = sclk;
    assign RCLK = rclk;
    assign OE_N = oe_n;
    assign BUSY = busy;

endmodule

// File: tb/tb_seven_seg_shifter.sv
// Directed bench: three instances (CLK_DIV 4, 1, 255) observed by a 74HC595 chain model.
module tb_seven_seg_shifter;

    logic        clk = 1'b0;
    logic [2:0]  rst = 3'b111;
    logic [15:0] word [3];
    logic [2:0]  ser, sclk, rclk, oe_n, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // 595 chain model and timing observers, one slot per instance
    logic [15:0] shift_m [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] latched [3] = '{16'h0, 16'h0, 16'h0};
    int sclk_rises [3] = '{0, 0, 0};
    int rclk_rises [3] = '{0, 0, 0};
    int busy_cnt   [3] = '{0, 0, 0};
    int busy_dur   [3] = '{0, 0, 0};
    int rclk_cnt   [3] = '{0, 0, 0};
    int rclk_len   [3] = '{0, 0, 0};
    int hp_cnt     [3] = '{0, 0, 0};
    int hp_min     [3] = '{100000, 100000, 100000};
    int hp_max     [3] = '{0, 0, 0};
    int ser_bad    [3] = '{0, 0, 0};
    logic [2:0] hp_valid = 3'b000;
    logic [2:0] ser_p = 3'b000, sclk_p = 3'b000, rclk_p = 3'b000, busy_p = 3'b000;

    always #5 clk = ~clk;

    seven_seg_shifter #(.CLK_DIV(4)) dut0 (
        .CLK(clk), .RESET(rst[0]), .CATHODE(word[0][7:0]), .ANODE(word[0][15:8]),
        .SER(ser[0]), .SCLK(sclk[0]), .RCLK(rclk[0]), .OE_N(oe_n[0]), .BUSY(busy[0])
    );
    seven_seg_shifter #(.CLK_DIV(1)) dut1 (
        .CLK(clk), .RESET(rst[1]), .CATHODE(word[1][7:0]), .ANODE(word[1][15:8]),
        .SER(ser[1]), .SCLK(sclk[1]), .RCLK(rclk[1]), .OE_N(oe_n[1]), .BUSY(busy[1])
    );
    seven_seg_shifter #(.CLK_DIV(255)) dut2 (
        .CLK(clk), .RESET(rst[2]), .CATHODE(word[2][7:0]), .ANODE(word[2][15:8]),
        .SER(ser[2]), .SCLK(sclk[2]), .RCLK(rclk[2]), .OE_N(oe_n[2]), .BUSY(busy[2])
    );

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (busy[i]) begin
                busy_cnt[i]++;
            end else begin
                if (busy_p[i]) busy_dur[i] = busy_cnt[i];
                busy_cnt[i] = 0;
                hp_valid[i] = 1'b0;
            end
            if (sclk[i] !== sclk_p[i]) begin
                if (hp_valid[i]) begin
                    if (hp_cnt[i] < hp_min[i]) hp_min[i] = hp_cnt[i];
                    if (hp_cnt[i] > hp_max[i]) hp_max[i] = hp_cnt[i];
                end
                hp_cnt[i]   = 1;
                hp_valid[i] = busy[i];
                if (sclk[i]) begin
                    sclk_rises[i]++;
                    shift_m[i] = {shift_m[i][14:0], ser[i]};
                end
            end else begin
                hp_cnt[i]++;
            end
            if (sclk[i] && ser[i] !== ser_p[i]) ser_bad[i]++;
            if (rclk[i] && !rclk_p[i]) begin
                rclk_rises[i]++;
                latched[i] = shift_m[i];
            end
            if (rclk[i]) begin
                rclk_cnt[i]++;
            end else begin
                if (rclk_p[i]) rclk_len[i] = rclk_cnt[i];
                rclk_cnt[i] = 0;
            end
            ser_p[i]  = ser[i];
            sclk_p[i] = sclk[i];
            rclk_p[i] = rclk[i];
            busy_p[i] = busy[i];
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input int idx, input logic lvl, input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (busy[idx] !== lvl && n < bound);
    endtask

    int n, base_s, base_r;

    initial begin
        word[0] = 16'hFE3F;
        word[1] = 16'hA5C3;
        word[2] = 16'h3C5A;
        repeat (3) step();

        check("rst_sclk", 32'(sclk[0]), 32'd0);
        check("rst_rclk", 32'(rclk[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_oe_n", 32'(oe_n[0]), 32'd1);
        check("rst_ser",  32'(ser[0]),  32'd0);

        // first transfer of FE3F
        rst[0] = 1'b0;
        wait_busy(0, 1'b1, 10, n);
        check("start_latency", 32'(n), 32'd1);
        check("load_ser", 32'(ser[0]), 32'd1);
        check("load_sclk", 32'(sclk[0]), 32'd0);
        n = 0;
        do begin step(); n++; end while (sclk[0] !== 1'b1 && n < 20);
        check("first_rise", 32'(n), 32'd5);
        check("oe_n_blank", 32'(oe_n[0]), 32'd1);
        wait_busy(0, 1'b0, 300, n);
        check("busy_dur_4", 32'(busy_dur[0]), 32'd133);
        check("oe_n_with_busy", 32'(oe_n[0]), 32'd0);
        check("sclk_rises", 32'(sclk_rises[0]), 32'd16);
        check("latched_fe3f", 32'(latched[0]), 32'h0000FE3F);
        check("rclk_pulses", 32'(rclk_rises[0]), 32'd1);
        check("rclk_len_4", 32'(rclk_len[0]), 32'd4);
        check("hp_min_4", 32'(hp_min[0]), 32'd4);
        check("hp_max_4", 32'(hp_max[0]), 32'd4);
        repeat (50) step();
        check("idle_busy", 32'(busy[0]), 32'd0);
        check("idle_rises", 32'(sclk_rises[0]), 32'd16);
        check("idle_rclk", 32'(rclk_rises[0]), 32'd1);

        // change to FD06, toggle three times mid-flight ending at FB5B
        word[0] = 16'hFD06;
        wait_busy(0, 1'b1, 10, n);
        check("change_start", 32'(n), 32'd1);
        base_r = rclk_rises[0];
        repeat (10) step();
        word[0] = 16'h1111;
        repeat (10) step();
        word[0] = 16'h2222;
        repeat (10) step();
        word[0] = 16'hFB5B;
        check("busy_hold", 32'(busy[0]), 32'd1);
        wait_busy(0, 1'b0, 300, n);
        check("latched_fd06", 32'(latched[0]), 32'h0000FD06);
        check("rclk_fd06", 32'(rclk_rises[0] - base_r), 32'd1);
        step();
        check("back_to_back", 32'(busy[0]), 32'd1);
        wait_busy(0, 1'b0, 300, n);
        check("latched_fb5b", 32'(latched[0]), 32'h0000FB5B);
        check("rclk_fb5b", 32'(rclk_rises[0] - base_r), 32'd2);
        check("busy_dur_fb5b", 32'(busy_dur[0]), 32'd133);
        repeat (40) step();
        check("no_extra_xfer", 32'(rclk_rises[0] - base_r), 32'd2);
        check("oe_n_sticky", 32'(oe_n[0]), 32'd0);

        // reset in the middle of a transfer
        word[0] = 16'h0F0F;
        wait_busy(0, 1'b1, 10, n);
        check("abort_xfer_start", 32'(n), 32'd1);
        base_s = sclk_rises[0];
        base_r = rclk_rises[0];
        n = 0;
        while (sclk_rises[0] != base_s + 7 && n < 300) begin step(); n++; end
        check("abort_point", 32'(sclk_rises[0] - base_s), 32'd7);
        rst[0] = 1'b1;
        step();
        check("abort_sclk", 32'(sclk[0]), 32'd0);
        check("abort_rclk", 32'(rclk[0]), 32'd0);
        check("abort_oe_n", 32'(oe_n[0]), 32'd1);
        check("abort_busy", 32'(busy[0]), 32'd0);
        rst[0] = 1'b0;
        wait_busy(0, 1'b1, 10, n);
        check("restart_latency", 32'(n), 32'd1);
        base_s = sclk_rises[0];
        wait_busy(0, 1'b0, 300, n);
        check("restart_rises", 32'(sclk_rises[0] - base_s), 32'd16);
        check("restart_rclk", 32'(rclk_rises[0] - base_r), 32'd1);
        check("latched_0f0f", 32'(latched[0]), 32'h00000F0F);
        check("restart_oe_n", 32'(oe_n[0]), 32'd0);

        // divider extremes
        rst[1] = 1'b0;
        rst[2] = 1'b0;
        wait_busy(2, 1'b1, 10, n);
        check("div_start", 32'(n), 32'd1);
        wait_busy(2, 1'b0, 9000, n);
        check("busy_dur_1", 32'(busy_dur[1]), 32'd34);
        check("busy_dur_255", 32'(busy_dur[2]), 32'd8416);
        check("hp_min_1", 32'(hp_min[1]), 32'd1);
        check("hp_max_1", 32'(hp_max[1]), 32'd1);
        check("hp_min_255", 32'(hp_min[2]), 32'd255);
        check("hp_max_255", 32'(hp_max[2]), 32'd255);
        check("latched_a5c3", 32'(latched[1]), 32'h0000A5C3);
        check("latched_3c5a", 32'(latched[2]), 32'h00003C5A);
        check("rclk_len_1", 32'(rclk_len[1]), 32'd1);
        check("rclk_len_255", 32'(rclk_len[2]), 32'd255);
        check("oe_n_div1", 32'(oe_n[1]), 32'd0);
        check("ser_stable_0", 32'(ser_bad[0]), 32'd0);
        check("ser_stable_1", 32'(ser_bad[1]), 32'd0);
        check("ser_stable_2", 32'(ser_bad[2]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
